// File: rtl/ex_mem_register_if.sv
// EX -> MEM pipeline bus. The execute stage drives the ex_* fields and the
// memory stage consumes the mem_* fields. The pipeline register sits between
// them on the slave modport.
interface ex_mem_register_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    // Execute-stage side
    logic                  ex_valid;
    logic [DATA_W-1:0]     ex_alu_result;
    logic [DATA_W-1:0]     ex_store_data;
    logic [REG_ADDR_W-1:0] ex_write_reg;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic                  ex_mem_write;
    logic [1:0]            ex_mem_size;
    logic                  ex_mem_unsigned;
    logic                  ex_mem_to_reg;
    logic [DATA_W-1:0]     ex_pc_plus4;

    // Memory-stage side
    logic                  mem_valid;
    logic [DATA_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [3:0]            mem_byte_en;
    logic                  mem_read;
    logic                  mem_write;
    logic [1:0]            mem_size;
    logic                  mem_unsigned;
    logic                  mem_reg_write;
    logic                  mem_mem_to_reg;
    logic [REG_ADDR_W-1:0] mem_write_reg;
    logic [DATA_W-1:0]     mem_pc_plus4;
    logic                  mem_misaligned;

    // Environment view: drives EX fields, observes MEM fields
    modport master (
        output ex_valid, ex_alu_result, ex_store_data, ex_write_reg,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_size,
               ex_mem_unsigned, ex_mem_to_reg, ex_pc_plus4,
        input  mem_valid, mem_addr, mem_wdata, mem_byte_en, mem_read,
               mem_write, mem_size, mem_unsigned, mem_reg_write,
               mem_mem_to_reg, mem_write_reg, mem_pc_plus4, mem_misaligned
    );

    // Pipeline register view: consumes EX fields, produces MEM fields
    modport slave (
        input  ex_valid, ex_alu_result, ex_store_data, ex_write_reg,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_size,
               ex_mem_unsigned, ex_mem_to_reg, ex_pc_plus4,
        output mem_valid, mem_addr, mem_wdata, mem_byte_en, mem_read,
               mem_write, mem_size, mem_unsigned, mem_reg_write,
               mem_mem_to_reg, mem_write_reg, mem_pc_plus4, mem_misaligned
    );
endinterface

// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register of the 5-stage MIPS core. Besides capturing the
// execute results it pre-computes store lane replication, byte enables and
// alignment faults so the data memory can use its inputs directly.
//
// Flow control: there is no valid/ready handshake. Each rising edge does, in
// priority order: flush (load a bubble, counter held), stall (hold
// everything, counter included), load (capture EX; ex_valid=0 loads a
// bubble). A bubble is all-zero outputs apart from misaligned_count.
module ex_mem_register #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 flush,
    ex_mem_register_if.slave     bus,
    output logic [CNT_W-1:0]     misaligned_count
);

    logic [1:0]        addr_lo;
    logic              access;
    logic              misaligned;
    logic [3:0]        byte_en_next;
    logic [DATA_W-1:0] wdata_next;
    logic              bubble;
    logic              load;

    assign addr_lo = bus.ex_alu_result[1:0];
    assign access  = bus.ex_mem_read | bus.ex_mem_write;
    assign bubble  = flush | (~stall & ~bus.ex_valid);
    assign load    = ~flush & ~stall & bus.ex_valid;

    // Alignment check; size 11 is treated as a word, bytes never fault
    always_comb begin
        misaligned = 1'b0;
        case (bus.ex_mem_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr_lo[0];
            default: misaligned = (addr_lo != 2'b00);
        endcase
        misaligned = misaligned & access;
    end

    // Store byte enables, suppressed for non-stores and faulting stores
    always_comb begin
        byte_en_next = 4'b0000;
        if (bus.ex_mem_write && !misaligned) begin
            case (bus.ex_mem_size)
                2'b00:   byte_en_next = 4'b0001 << addr_lo;
                2'b01:   byte_en_next = addr_lo[1] ? 4'b1100 : 4'b0011;
                default: byte_en_next = 4'b1111;
            endcase
        end
    end

    // Little-endian lane replication, independent of store qualification
    always_comb begin
        wdata_next = bus.ex_store_data;
        case (bus.ex_mem_size)
            2'b00:   wdata_next = {4{bus.ex_store_data[7:0]}};
            2'b01:   wdata_next = {2{bus.ex_store_data[15:0]}};
            default: wdata_next = bus.ex_store_data;
        endcase
    end

    // Pipeline register: reset > flush/bubble > stall > load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || bubble) begin
            bus.mem_valid      <= 1'b0;
            bus.mem_addr       <= '0;
            bus.mem_wdata      <= '0;
            bus.mem_byte_en    <= 4'b0000;
            bus.mem_read       <= 1'b0;
            bus.mem_write      <= 1'b0;
            bus.mem_size       <= 2'b00;
            bus.mem_unsigned   <= 1'b0;
            bus.mem_reg_write  <= 1'b0;
            bus.mem_mem_to_reg <= 1'b0;
            bus.mem_write_reg  <= '0;
            bus.mem_pc_plus4   <= '0;
            bus.mem_misaligned <= 1'b0;
        end else if (load) begin
            bus.mem_valid      <= 1'b1;
            bus.mem_addr       <= bus.ex_alu_result;
            bus.mem_wdata      <= wdata_next;
            bus.mem_byte_en    <= byte_en_next;
            bus.mem_read       <= bus.ex_mem_read & ~misaligned;
            bus.mem_write      <= bus.ex_mem_write & ~misaligned;
            bus.mem_size       <= bus.ex_mem_size;
            bus.mem_unsigned   <= bus.ex_mem_unsigned;
            bus.mem_reg_write  <= bus.ex_reg_write & ~misaligned &
                                  (bus.ex_write_reg != '0);
            bus.mem_mem_to_reg <= bus.ex_mem_to_reg;
            bus.mem_write_reg  <= bus.ex_write_reg;
            bus.mem_pc_plus4   <= bus.ex_pc_plus4;
            bus.mem_misaligned <= misaligned;
        end
    end

    // Saturating fault counter; only real loaded instructions count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned_count <= '0;
        end else if (load && misaligned && (misaligned_count != {CNT_W{1'b1}})) begin
            misaligned_count <= misaligned_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_mem_register.sv
// Directed bench for the EX/MEM pipeline register with hand-computed
// expectations.
module tb_ex_mem_register;

    logic       clk;
    logic       rst_n;
    logic       stall;
    logic       flush;
    logic [7:0] misaligned_count;

    int total;
    int bad;

    ex_mem_register_if bus ();

    ex_mem_register dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .flush            (flush),
        .bus              (bus),
        .misaligned_count (misaligned_count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one EX-stage instruction
    task automatic drive_ex(input logic valid, input logic [31:0] alu, input logic [31:0] sd,
                            input logic [4:0] wr, input logic rw, input logic rd, input logic wrt,
                            input logic [1:0] size, input logic uns, input logic m2r,
                            input logic [31:0] pc);
        bus.ex_valid        = valid;
        bus.ex_alu_result   = alu;
        bus.ex_store_data   = sd;
        bus.ex_write_reg    = wr;
        bus.ex_reg_write    = rw;
        bus.ex_mem_read     = rd;
        bus.ex_mem_write    = wrt;
        bus.ex_mem_size     = size;
        bus.ex_mem_unsigned = uns;
        bus.ex_mem_to_reg   = m2r;
        bus.ex_pc_plus4     = pc;
    endtask

    // Advance one edge and sample away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_valid"},  {31'd0, bus.mem_valid}, 32'd0);
        check({tag, "_addr"},   bus.mem_addr, 32'd0);
        check({tag, "_wdata"},  bus.mem_wdata, 32'd0);
        check({tag, "_be"},     {28'd0, bus.mem_byte_en}, 32'd0);
        check({tag, "_strobes"}, {28'd0, bus.mem_read, bus.mem_write, bus.mem_reg_write,
                                  bus.mem_misaligned}, 32'd0);
        check({tag, "_misc"},   {24'd0, bus.mem_size, bus.mem_unsigned, bus.mem_mem_to_reg,
                                 bus.mem_write_reg}, 32'd0);
        check({tag, "_pc"},     bus.mem_pc_plus4, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive_ex(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'd0);
        #12;
        check_bubble("reset");
        check("reset_cnt", {24'd0, misaligned_count}, 32'd0);
        rst_n = 1'b1;
        step();
        check_bubble("idle");
        check("idle_cnt", {24'd0, misaligned_count}, 32'd0);

        // sb at 0x1003
        drive_ex(1'b1, 32'h1003, 32'h0000_00AB, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h400);
        step();
        check("sb_valid", {31'd0, bus.mem_valid}, 32'd1);
        check("sb_wdata", bus.mem_wdata, 32'hABAB_ABAB);
        check("sb_be", {28'd0, bus.mem_byte_en}, 32'b1000);
        check("sb_write", {31'd0, bus.mem_write}, 32'd1);
        check("sb_mis", {31'd0, bus.mem_misaligned}, 32'd0);
        check("sb_pc", bus.mem_pc_plus4, 32'h400);

        // lbu at 0x1001 to $9: bytes never fault
        drive_ex(1'b1, 32'h1001, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 32'h404);
        step();
        check("lbu_read", {31'd0, bus.mem_read}, 32'd1);
        check("lbu_rw", {31'd0, bus.mem_reg_write}, 32'd1);
        check("lbu_uns", {31'd0, bus.mem_unsigned}, 32'd1);
        check("lbu_be", {28'd0, bus.mem_byte_en}, 32'd0);
        check("lbu_wreg", {27'd0, bus.mem_write_reg}, 32'd9);

        // sw at 0x1002: misaligned
        drive_ex(1'b1, 32'h1002, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h408);
        step();
        check("sw_write", {31'd0, bus.mem_write}, 32'd0);
        check("sw_be", {28'd0, bus.mem_byte_en}, 32'd0);
        check("sw_mis", {31'd0, bus.mem_misaligned}, 32'd1);
        check("sw_addr", bus.mem_addr, 32'h1002);
        check("sw_wdata", bus.mem_wdata, 32'h1234_5678);
        check("sw_cnt1", {24'd0, misaligned_count}, 32'd1);
        for (int i = 1; i < 300; i++) begin
            step();
            if (i == 100) check("sw_cnt101", {24'd0, misaligned_count}, 32'd101);
        end
        check("sw_cnt_sat", {24'd0, misaligned_count}, 32'd255);

        // lw to $0 at 0x2000
        drive_ex(1'b1, 32'h2000, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h40C);
        step();
        check("lw0_read", {31'd0, bus.mem_read}, 32'd1);
        check("lw0_rw", {31'd0, bus.mem_reg_write}, 32'd0);
        check("lw0_m2r", {31'd0, bus.mem_mem_to_reg}, 32'd1);
        check("lw0_mis", {31'd0, bus.mem_misaligned}, 32'd0);

        // addu to $8
        drive_ex(1'b1, 32'h0000_0055, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h410);
        step();
        check("addu_rw", {31'd0, bus.mem_reg_write}, 32'd1);
        check("addu_addr", bus.mem_addr, 32'h55);
        check("addu_read", {31'd0, bus.mem_read}, 32'd0);

        // lhu at 0x11 to $3: misaligned half load, counter stays saturated
        drive_ex(1'b1, 32'h11, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 32'h414);
        step();
        check("lhu_mis", {31'd0, bus.mem_misaligned}, 32'd1);
        check("lhu_read_rw", {30'd0, bus.mem_read, bus.mem_reg_write}, 32'd0);
        check("lhu_cnt", {24'd0, misaligned_count}, 32'd255);

        // size 11 store at 0x4 behaves as aligned word
        drive_ex(1'b1, 32'h4, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 32'h418);
        step();
        check("sz3_be", {28'd0, bus.mem_byte_en}, 32'b1111);
        check("sz3_wdata", bus.mem_wdata, 32'hCAFE_F00D);
        check("sz3_size", {30'd0, bus.mem_size}, 32'd3);

        // size 11 store at 0x5 faults
        drive_ex(1'b1, 32'h5, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 32'h41C);
        step();
        check("sz3mis_mis", {31'd0, bus.mem_misaligned}, 32'd1);
        check("sz3mis_write", {31'd0, bus.mem_write}, 32'd0);

        // sh at 0x10, then stall three cycles with changing inputs
        drive_ex(1'b1, 32'h10, 32'h0000_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h420);
        step();
        check("sh_be", {28'd0, bus.mem_byte_en}, 32'b0011);
        check("sh_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_ex(1'b1, 32'h12 + 32'(i * 4), 32'h0000_1234, 5'd0, 1'b0, 1'b0, 1'b1, 2'b01,
                     1'b0, 1'b0, 32'h424);
            step();
            check("stall_be", {28'd0, bus.mem_byte_en}, 32'b0011);
            check("stall_addr", bus.mem_addr, 32'h10);
            check("stall_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
        end
        // last driven: sh at 0x1A -> upper half
        stall = 1'b0;
        step();
        check("unstall_addr", bus.mem_addr, 32'h1A);
        check("unstall_be", {28'd0, bus.mem_byte_en}, 32'b1100);
        check("unstall_wdata", bus.mem_wdata, 32'h1234_1234);
        check("unstall_pc", bus.mem_pc_plus4, 32'h424);

        // stall and flush together: bubble, counter held
        stall = 1'b1;
        flush = 1'b1;
        step();
        check_bubble("flush");
        check("flush_cnt", {24'd0, misaligned_count}, 32'd255);
        stall = 1'b0;
        flush = 1'b0;

        // valid instruction, then reset dropped mid-cycle
        drive_ex(1'b1, 32'h77, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h428);
        step();
        check("pre_rst_valid", {31'd0, bus.mem_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_bubble("async_rst");
        check("async_rst_cnt", {24'd0, misaligned_count}, 32'd0);
        #10;
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_register.md
Name: ex_mem_register

Overview:
Pipeline register between the execute stage and the memory-access stage (stage 3 → stage 4) of the 5-stage MIPS core. Captures the EX results and control bits on each clock. Pre-computes store-data lane replication, byte enables and alignment checks, so the data memory in stage 4 sees ready-to-use signals. Supports stall (hold) and flush (bubble insertion), and keeps a saturating count of misaligned accesses.

Parameters:
DATA_W, 32, datapath width; only 32 is supported.
REG_ADDR_W, 5, register-file address width.
CNT_W, 8, width of the misaligned-access counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
stall  input  1  hold all registered outputs this cycle
flush  input  1  load a bubble this cycle
ex_valid  input  1  EX holds a real instruction
ex_alu_result  input  32  ALU result / effective address
ex_store_data  input  32  rt value for stores
ex_write_reg  input  5  destination register
ex_reg_write  input  1  instruction writes the register file
ex_mem_read  input  1  load
ex_mem_write  input  1  store
ex_mem_size  input  2  00 byte, 01 half, 10 word; 11 is illegal and treated as word
ex_mem_unsigned  input  1  zero-extend loads (lbu/lhu)
ex_mem_to_reg  input  1  writeback selects memory data
ex_pc_plus4  input  32  PC+4 for link instructions
mem_valid  output  1  registered valid
mem_addr  output  32  registered ALU result
mem_wdata  output  32  lane-replicated store data
mem_byte_en  output  4  store byte enables; bit0 = addr[1:0]==00
mem_read  output  1  qualified load strobe
mem_write  output  1  qualified store strobe
mem_size  output  2  registered size
mem_unsigned  output  1  registered unsigned flag
mem_reg_write  output  1  qualified register write
mem_mem_to_reg  output  1  registered writeback select
mem_write_reg  output  5  registered destination
mem_pc_plus4  output  32  registered PC+4
mem_misaligned  output  1  registered instruction is a misaligned access
misaligned_count  output  8  saturating count of misaligned accesses

Behaviour:
- Reset (rst_n low, asynchronous): every output is 0, including misaligned_count. The register leaves reset on the first rising edge after rst_n is high.
- Update priority at each rising edge: reset > flush > stall > load.
- Flush: loads a bubble. All outputs go to 0 except misaligned_count, which is held. Flush wins over a simultaneous stall.
- Stall (no flush): all outputs hold, including the counter.
- Load (no stall, no flush): captures the EX inputs with the following qualification rules.
  - If ex_valid = 0, load a bubble exactly as for flush.
  - Misaligned condition, only when mem_read or mem_write is requested:
    - half access with addr[0] = 1;
    - word (or size 11) access with addr[1:0] ≠ 00.
    - Byte accesses are never misaligned.
  - When misaligned:
    - mem_misaligned = 1;
    - mem_read, mem_write, mem_reg_write and mem_byte_en are forced to 0;
    - mem_addr still holds the faulting address;
    - misaligned_count increments by 1 and saturates at 255.
  - mem_reg_write is forced to 0 when ex_write_reg = 0.
  - mem_byte_en, only when the store is not misaligned:
    - byte: 1 shifted left by addr[1:0];
    - half: 0011 if addr[1] = 0, 1100 if addr[1] = 1;
    - word: 1111.
    - 0000 for any non-store.
  - mem_wdata (little-endian lanes), computed for every load regardless of store qualification:
    - byte: store_data[7:0] replicated ×4;
    - half: store_data[15:0] replicated ×2;
    - word: unchanged.
- Latency: exactly 1 cycle from the EX inputs to the outputs. No combinational path from any input to any output.
- Reset asserted mid-stall or mid-flush clears state immediately; the counter also clears.

Test Plan:
- Reset, then release with ex_valid = 0 → all outputs 0 after the first edge; misaligned_count = 0.
- sb: addr 0x1003, store_data 0x000000AB → mem_wdata 0xABABABAB, mem_byte_en 1000, mem_write 1, mem_misaligned 0.
- sw: addr 0x1002 → mem_write 0, mem_byte_en 0000, mem_misaligned 1, mem_addr 0x1002, misaligned_count 1. Repeat 300 times → count saturates at 255.
- lw to $0: addr 0x2000 → mem_read 1, mem_reg_write 0. Then an addu with write_reg 8 → mem_reg_write 1, mem_addr = ALU result.
- Load a sh at addr 0x10, then assert stall for 3 cycles while changing the inputs → outputs stay at the sh values (byte_en 0011). Deassert stall → the new inputs appear on the next edge.
- Assert stall and flush together → bubble: mem_valid 0, all strobes 0, counter unchanged. Assert rst_n low mid-cycle → outputs 0 immediately, without waiting for a clock edge.
